i2c_sda_monitor: RTL

Cycle-accurate receive-side monitor that sits directly downstream of the I2C controller and consumes its serial `sda` output, together with a tap of the controller's `start` request. It reconstructs each frame (start cycle, 8 address bits, 1..N data bytes each followed by one ACK cycle) and presents the address and data bytes as parallel words with single-cycle valid pulses. It also flags protocol violations. It is used as a loopback checker in the controller testbench and as the parallel-side observer in system integration.

---
 rtl/i2c_sda_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2c_sda_monitor.sv
// i2c_sda_monitor: receive-side decoder for the controller's serial sda stream.
// Rebuilds start/address/data/ACK framing, presents parallel words with
// single-cycle valid pulses and flags protocol violations. All outputs are flops.
module i2c_sda_monitor #(
  parameter logic [7:0] EXP_ADDR = 8'hA9,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sda,
  input  logic             start,
  output logic [7:0]       addr,
  output logic             addr_valid,
  output logic             addr_match,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             frame_active,
  output logic             frame_end,
  output logic [CNT_W-1:0] byte_count,
  output logic             err,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       addr_q, addr_d;
  logic             addr_valid_q, addr_valid_d;
  logic             addr_match_q, addr_match_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_active_q, frame_active_d;
  logic             frame_end_q, frame_end_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [7:0]       shift_next_s;

  // Next-state and next-output logic; the 8th sampled bit completes a byte.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    addr_d         = addr_q;
    addr_valid_d   = 1'b0;
    addr_match_d   = addr_match_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    frame_active_d = frame_active_q;
    frame_end_d    = 1'b0;
    byte_count_d   = byte_count_q;
    err_d          = 1'b0;
    shift_next_s   = {shift_q[6:0], sda};

    case (state_q)
      S_IDLE: begin
        if (start && !sda) begin
          state_d        = S_ADDR;
          bit_cnt_d      = 3'd0;
          byte_count_d   = {CNT_W{1'b0}};
          frame_active_d = 1'b1;
        end else if (start == sda) begin
          // start with sda high, or sda low without a start request
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        shift_d   = shift_next_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          addr_d       = shift_next_s;
          addr_valid_d = 1'b1;
          addr_match_d = (shift_next_s == EXP_ADDR);
          bit_cnt_d    = 3'd0;
          state_d      = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        shift_d   = shift_next_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_d       = shift_next_s;
          data_valid_d = 1'b1;
          if (byte_count_q != CNT_MAX) begin
            byte_count_d = byte_count_q + CNT_ONE;
          end else begin
            byte_count_d = byte_count_q;
          end
          bit_cnt_d = 3'd0;
          state_d   = S_ACK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_ACK: begin
        if (!sda) begin
          // missing ACK aborts the frame without a frame_end
          err_d          = 1'b1;
          frame_active_d = 1'b0;
          state_d        = S_IDLE;
        end else if (start) begin
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          frame_end_d    = 1'b1;
          frame_active_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d        = S_IDLE;
        frame_active_d = 1'b0;
      end
    endcase

    err_sticky_d = err_sticky_q | err_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'd0;
      addr_q         <= 8'd0;
      addr_valid_q   <= 1'b0;
      addr_match_q   <= 1'b0;
      data_q         <= 8'd0;
      data_valid_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      byte_count_q   <= {CNT_W{1'b0}};
      err_q          <= 1'b0;
      err_sticky_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      addr_q         <= addr_d;
      addr_valid_q   <= addr_valid_d;
      addr_match_q   <= addr_match_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      byte_count_q   <= byte_count_d;
      err_q          <= err_d;
      err_sticky_q   <= err_sticky_d;
    end
  end

  assign addr         = addr_q;
  assign addr_valid   = addr_valid_q;
  assign addr_match   = addr_match_q;
  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign frame_active = frame_active_q;
  assign frame_end    = frame_end_q;
  assign byte_count   = byte_count_q;
  assign err          = err_q;
  assign err_sticky   = err_sticky_q;

endmodule
